// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK command encoding and next-state to {J,K} mapping
package jk_pkg;

    // {J,K} command applied to one JK cell
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_e;

    // Only drives the bit toward its next value, so J=K=1 is never produced
    // and an unchanged bit always gets HOLD.
    function automatic logic [1:0] jk_of(input logic cur, input logic nxt);
        return {~cur & nxt, cur & ~nxt};
    endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - rising-edge JK flip-flop with asynchronous active-high clear
// clk: clock; CLR: async clear (Q=0); J/K: command; Q: state; QBAR: ~Q
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic CLR,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic QBAR
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case (jk_cmd_e'({J, K}))
            JK_HOLD: q_d = q_q;
            JK_RST:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TGL:  q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q    = q_q;
    assign QBAR = ~q_q;

endmodule

// File: rtl/jk_sync_updown_counter.sv
// rtl/jk_sync_updown_counter.sv - modulo-MODULUS up/down counter built from JK cells
// clk: clock; CLR: async clear; en: count enable; up: 1=inc 0=dec; ld/d: sync load
// q/qbar: count and complement; tc: comb terminal count; co: registered wrap pulse;
// ovr: sticky illegal-load flag
module jk_sync_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             co,
    output logic             ovr
);

    if (WIDTH < 2 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_params
        $error("jk_sync_updown_counter: illegal WIDTH/MODULUS");
    end

    // One extra bit so MODULUS == 2**WIDTH still compares correctly
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] nxt_d;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic             co_q, co_d;
    logic             ovr_q, ovr_d;
    logic             q_in_range;

    assign q_in_range = ({1'b0, q} < MOD_X);
    assign tc         = en & ~ld & (up ? (q == Q_MAX) : (q == '0));

    always_comb begin
        nxt_d = q;
        ovr_d = ovr_q;
        co_d  = 1'b0;
        if (ld) begin
            if ({1'b0, d} < MOD_X) begin
                nxt_d = d;
                ovr_d = 1'b0;
            end else begin
                nxt_d = '0;
                ovr_d = 1'b1;
            end
        end else if (en) begin
            if (!q_in_range) begin
                // Recovery from a corrupted state, not a wrap
                nxt_d = '0;
            end else if (up) begin
                nxt_d = (q == Q_MAX) ? '0 : q + WIDTH'(1);
                co_d  = (q == Q_MAX);
            end else begin
                nxt_d = (q == '0) ? Q_MAX : q - WIDTH'(1);
                co_d  = (q == '0);
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign {cell_j[i], cell_k[i]} = jk_of(q[i], nxt_d[i]);

        jk_cell u_cell (
            .clk  (clk),
            .CLR  (CLR),
            .J    (cell_j[i]),
            .K    (cell_k[i]),
            .Q    (q[i]),
            .QBAR (qbar[i])
        );
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            co_q  <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            co_q  <= co_d;
            ovr_q <= ovr_d;
        end
    end

    assign co  = co_q;
    assign ovr = ovr_q;

endmodule

// File: tb/tb_jk_sync_updown_counter.sv
// tb/tb_jk_sync_updown_counter.sv - self-checking bench for jk_sync_updown_counter
module tb_jk_sync_updown_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk;
    logic         CLR;
    logic         en;
    logic         up;
    logic         ld;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         tc;
    logic         co;
    logic         ovr;

    int n_checks;
    int n_errors;

    // Reference state: count, pending wrap pulse, sticky overrange flag
    int m_q;
    int m_co;
    int m_ovr;

    jk_sync_updown_counter #(
        .WIDTH   (W),
        .MODULUS (MOD)
    ) dut (
        .clk  (clk),
        .CLR  (CLR),
        .en   (en),
        .up   (up),
        .ld   (ld),
        .d    (d),
        .q    (q),
        .qbar (qbar),
        .tc   (tc),
        .co   (co),
        .ovr  (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_tc();
        if (!en || ld) return 0;
        return up ? int'(m_q == MOD - 1) : int'(m_q == 0);
    endfunction

    task automatic model_reset();
        m_q   = 0;
        m_co  = 0;
        m_ovr = 0;
    endtask

    task automatic model_step();
        int old_q;
        old_q = m_q;
        m_co  = 0;
        if (ld) begin
            if (int'(d) < MOD) begin
                m_q   = int'(d);
                m_ovr = 0;
            end else begin
                m_q   = 0;
                m_ovr = 1;
            end
        end else if (en) begin
            if (up) begin
                m_q  = (old_q + 1) % MOD;
                m_co = int'(m_q < old_q);
            end else begin
                m_q  = (old_q + MOD - 1) % MOD;
                m_co = int'(m_q > old_q);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " q"},    int'(q),    m_q);
        check({tag, " qbar"}, int'(qbar), (~m_q) & ((1 << W) - 1));
        check({tag, " co"},   int'(co),   m_co);
        check({tag, " ovr"},  int'(ovr),  m_ovr);
    endtask

    // One clock: apply inputs, check tc, clock edge, check registered outputs
    task automatic cycle(input string tag, input logic i_en, input logic i_up,
                         input logic i_ld, input int i_d);
        logic [W-1:0] dv;
        dv = W'(i_d);
        en = i_en;
        up = i_up;
        ld = i_ld;
        d  = dv;
        #1;
        check({tag, " tc"}, int'(tc), model_tc());
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    // Clear pulse placed between clock edges; outputs must clear without an edge
    task automatic mid_cycle_clear(input string tag);
        #2;
        CLR = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        #2;
        CLR = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        CLR = 1'b1;
        en  = 1'b0;
        up  = 1'b1;
        ld  = 1'b0;
        d   = '0;
        model_reset();
        #12;
        check_outputs("reset");
        CLR = 1'b0;

        // Count up through a full wrap
        for (int i = 0; i < 10; i++) cycle("up10", 1'b1, 1'b1, 1'b0, 0);
        // Count down through the 0 -> 9 wrap
        for (int i = 0; i < 3; i++) cycle("down3", 1'b1, 1'b0, 1'b0, 0);
        // Load wins over enable
        cycle("ld5", 1'b0, 1'b0, 1'b1, 5);
        cycle("ld_en", 1'b1, 1'b1, 1'b1, 6);
        cycle("after_ld", 1'b1, 1'b1, 1'b0, 0);
        // Illegal load sets the sticky flag; counting leaves it alone
        cycle("ld12", 1'b0, 1'b1, 1'b1, 12);
        for (int i = 0; i < 5; i++) cycle("ovr_hold", 1'b1, 1'($urandom_range(1)), 1'b0, 0);
        cycle("ld3", 1'b0, 1'b1, 1'b1, 3);
        // Asynchronous clear mid-cycle
        cycle("ld7", 1'b0, 1'b1, 1'b1, 7);
        cycle("ovr_set", 1'b0, 1'b1, 1'b1, 15);
        mid_cycle_clear("async_clr");
        cycle("post_clr", 1'b1, 1'b1, 1'b0, 0);
        // Direction changes and hold
        cycle("ld4", 1'b0, 1'b1, 1'b1, 4);
        cycle("dir_up", 1'b1, 1'b1, 1'b0, 0);
        cycle("dir_dn", 1'b1, 1'b0, 1'b0, 0);
        cycle("dir_dn", 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) cycle("hold", 1'b0, 1'($urandom_range(1)), 1'b0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 2) begin
                mid_cycle_clear("rnd_clr");
            end else begin
                cycle("rnd", 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                      1'($urandom_range(7) == 0), int'($urandom_range(15)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
